// File: rtl/hamm_dec_pipe.sv
// hamm_dec_pipe: two-stage SEC-DED decoder for 6-bit data in a 16-bit codeword.
// Ports: clk, rst (sync, high), in_valid/in_ready/in[15:0] codeword stream,
//   out_valid/out_ready/out[5:0] data stream, err_corr/err_uncorr/err_pos status,
//   cnt_clr/cnt_corr/cnt_uncorr error statistics.
// Build macro HAMM_DEC_STATS_EN: when defined, the saturating counters exist;
//   otherwise cnt_corr/cnt_uncorr are tied to 0 and cnt_clr is ignored.
module hamm_dec_pipe #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [5:0]       out,
   output logic             err_corr,
   output logic             err_uncorr,
   output logic [3:0]       err_pos,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] cnt_corr,
   output logic [CNT_W-1:0] cnt_uncorr
);

   logic        s2_adv;
   logic        s1_valid;
   logic [10:0] s1_cw;
   logic [3:0]  s1_syn;
   logic        s1_par;
   logic [3:0]  syn;
   logic        par;

   logic [10:0] fix;
   logic [5:0]  d_nxt;
   logic        c_nxt;
   logic        u_nxt;
   logic [3:0]  p_nxt;

   // Padding bits carry no information.
   logic unused_pad;
   assign unused_pad = ^in[15:11];

   assign s2_adv   = !out_valid || out_ready;
   assign in_ready = !rst && (!s1_valid || s2_adv);

   always_comb begin
      syn = '0;
      for (int i = 1; i <= 10; i++) begin
         if (in[i]) syn = syn ^ 4'(i);
      end
   end

   assign par = ^in[10:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_cw    <= '0;
         s1_syn   <= '0;
         s1_par   <= 1'b0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_cw  <= in[10:0];
            s1_syn <= syn;
            s1_par <= par;
         end
      end
   end

   // Odd parity with s=0 means only p0 flipped; flipping bit 0 leaves data intact.
   always_comb begin
      fix   = s1_cw;
      c_nxt = 1'b0;
      u_nxt = 1'b0;
      p_nxt = '0;
      unique case (1'b1)
         (!s1_par && s1_syn == 4'd0): begin
         end
         (s1_par && s1_syn <= 4'd10): begin
            c_nxt = 1'b1;
            p_nxt = s1_syn;
            fix   = s1_cw ^ (11'd1 << s1_syn);
         end
         default: begin
            u_nxt = 1'b1;
         end
      endcase
      d_nxt = {fix[10], fix[9], fix[7], fix[6], fix[5], fix[3]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out        <= '0;
         err_corr   <= 1'b0;
         err_uncorr <= 1'b0;
         err_pos    <= '0;
      end else if (s2_adv) begin
         out_valid  <= s1_valid;
         out        <= d_nxt;
         err_corr   <= c_nxt;
         err_uncorr <= u_nxt;
         err_pos    <= p_nxt;
      end
   end

`ifdef HAMM_DEC_STATS_EN
   logic ohs;
   assign ohs = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         cnt_corr   <= '0;
         cnt_uncorr <= '0;
      end else if (ohs) begin
         if (err_corr && cnt_corr != '1)
            cnt_corr <= cnt_corr + CNT_W'(1);
         if (err_uncorr && cnt_uncorr != '1)
            cnt_uncorr <= cnt_uncorr + CNT_W'(1);
      end
   end
`else
   logic unused_clr;
   assign unused_clr = cnt_clr;
   assign cnt_corr   = '0;
   assign cnt_uncorr = '0;
`endif

endmodule
